// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs UART bytes big-endian into words and writes them
// sequentially into instruction memory until a HALT word, full memory or timeout.
module inst_mem_loader #(
  parameter int INST_SZ = 32,
  parameter int PC_SZ = 32,
  parameter int BYTE_SZ = 8,
  parameter int MEM_DEPTH = 256,
  parameter logic [INST_SZ-1:0] HALT_INST = 32'hFFFFFFFF,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [PC_SZ-1:0]   o_addr,
  output logic               o_loading,
  output logic               o_done,
  output logic               o_error,
  output logic [PC_SZ-1:0]   o_inst_count
);
  localparam int BPW = INST_SZ / BYTE_SZ;
  localparam int BW = $clog2(BPW + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PC_SZ-1:0] LAST_ADDR = PC_SZ'((MEM_DEPTH - 1) * 4);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [INST_SZ-1:0] word, word_n, last, last_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [PC_SZ-1:0] addr, addr_n, cnt, cnt_n;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      word <= '0;
      last <= '0;
      bcnt <= '0;
      tmo <= '0;
      addr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      word <= word_n;
      last <= last_n;
      bcnt <= bcnt_n;
      tmo <= tmo_n;
      addr <= addr_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    word_n = word;
    last_n = last;
    bcnt_n = bcnt;
    tmo_n = tmo;
    addr_n = addr;
    cnt_n = cnt;
    case (state)
      RECV: begin
        if (i_rx_valid) begin
          word_n = {word[INST_SZ-BYTE_SZ-1:0], i_rx_data};
          tmo_n = '0;
          bcnt_n = (bcnt == BW'(BPW - 1)) ? '0 : bcnt + 1'b1;
          state_n = (bcnt == BW'(BPW - 1)) ? WRITE : RECV;
        end else if (bcnt != '0) begin
          // only a partially received word can time out
          tmo_n = (tmo == TW'(TIMEOUT_CYC - 1)) ? '0 : tmo + 1'b1;
          state_n = (tmo == TW'(TIMEOUT_CYC - 1)) ? ERROR : RECV;
        end
      end
      WRITE: begin
        last_n = word;
        cnt_n = cnt + 1'b1;
        tmo_n = '0;
        // a byte arriving during the write starts the next word
        word_n = i_rx_valid ? INST_SZ'(i_rx_data) : word;
        bcnt_n = i_rx_valid ? BW'(1) : '0;
        state_n = (word == HALT_INST) ? DONE : (addr == LAST_ADDR) ? ERROR : RECV;
        addr_n = (word == HALT_INST || addr == LAST_ADDR) ? addr : addr + PC_SZ'(4);
      end
      default: begin
        if (i_start) begin
          state_n = RECV;
          addr_n = '0;
          cnt_n = '0;
          bcnt_n = '0;
          tmo_n = '0;
        end
      end
    endcase
  end
  assign o_write = state == WRITE;
  assign o_instruction = o_write ? word : last;
  assign o_addr = addr;
  assign o_loading = state == RECV || state == WRITE;
  assign o_done = state == DONE;
  assign o_error = state == ERROR;
  assign o_inst_count = cnt;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed vectors against a loader built with a 4-word
// memory and a 10-cycle inter-byte timeout.
module tb_inst_mem_loader;
  logic clk, rst_n, start, rx_valid;
  logic [7:0] rx_data;
  logic wr, loading, done, err;
  logic [31:0] instr, addr, cnt;
  int n_cmp = 0, n_bad = 0, wr_n = 0, base = 0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];

  inst_mem_loader #(.MEM_DEPTH(4), .TIMEOUT_CYC(10)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_write(wr), .o_instruction(instr), .o_addr(addr),
    .o_loading(loading), .o_done(done), .o_error(err), .o_inst_count(cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (wr && wr_n < 64) begin
    wa[wr_n] = addr;
    wd[wr_n] = instr;
    wr_n++;
    check("wr_vs_err", {31'b0, err}, 32'd0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    base = wr_n;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr"}, {31'b0, wr}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_load"}, {31'b0, loading}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_cnt"}, cnt, 32'd0);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, wa[base + i], a);
    check({tag, "_data"}, wd[base + i], d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; rx_valid = 0; rx_data = 0;
    idle(2);
    check_zero("rst");
    rst_n = 1;
    idle(1);
    // three-word program ending in HALT, gaps between words
    pulse_start();
    check("arm_load", {31'b0, loading}, 32'd1);
    send_word(32'h20010005); idle(2);
    send_word(32'h20020003); idle(2);
    send_word(32'hFFFFFFFF);
    idle(1);
    check("prog_nwr", wr_n - base, 3);
    check_wr("prog_w0", 0, 32'd0, 32'h20010005);
    check_wr("prog_w1", 1, 32'd4, 32'h20020003);
    check_wr("prog_w2", 2, 32'd8, 32'hFFFFFFFF);
    check("prog_done", {31'b0, done}, 32'd1);
    check("prog_cnt", cnt, 32'd3);
    check("prog_load", {31'b0, loading}, 32'd0);
    check("prog_addr_hold", addr, 32'd8);
    check("prog_instr_hold", instr, 32'hFFFFFFFF);
    // re-arm from DONE
    base = wr_n;
    pulse_start();
    check("rearm_done", {31'b0, done}, 32'd0);
    check("rearm_addr", addr, 32'd0);
    check("rearm_cnt", cnt, 32'd0);
    send_word(32'h20030007); idle(1);
    send_word(32'hFFFFFFFF); idle(1);
    check("rearm_nwr", wr_n - base, 2);
    check_wr("rearm_w0", 0, 32'd0, 32'h20030007);
    check_wr("rearm_w1", 1, 32'd4, 32'hFFFFFFFF);
    check("rearm_cnt_end", cnt, 32'd2);
    check("rearm_done_end", {31'b0, done}, 32'd1);
    // reset mid-word discards it
    pulse_start();
    send(8'h12); send(8'h34);
    rst_n = 0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1;
    base = wr_n;
    pulse_start();
    send(8'h8C); send(8'h01); send(8'h00); send(8'h04);
    check("lat_wr", {31'b0, wr}, 32'd1);
    check("lat_instr", instr, 32'h8C010004);
    check("lat_addr", addr, 32'd0);
    idle(2);
    check("single_nwr", wr_n - base, 1);
    check("single_cnt", cnt, 32'd1);
    check("single_load", {31'b0, loading}, 32'd1);
    check("single_wr_low", {31'b0, wr}, 32'd0);
    // back-to-back bytes, the fifth arrives in the WRITE cycle
    do_reset();
    pulse_start();
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'hFFFFFFFF);
    idle(1);
    check("b2b_nwr", wr_n - base, 3);
    check_wr("b2b_w0", 0, 32'd0, 32'h11223344);
    check_wr("b2b_w1", 1, 32'd4, 32'h55667788);
    check_wr("b2b_w2", 2, 32'd8, 32'hFFFFFFFF);
    check("b2b_done", {31'b0, done}, 32'd1);
    // memory full without HALT
    do_reset();
    pulse_start();
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    send_word(32'h0D0E0F10);
    idle(1);
    check("full_err", {31'b0, err}, 32'd1);
    check("full_cnt", cnt, 32'd4);
    check("full_addr", addr, 32'd12);
    check_wr("full_w0", 0, 32'd0, 32'h01020304);
    check_wr("full_w3", 3, 32'd12, 32'h0D0E0F10);
    send_word(32'hAABBCCDD);
    idle(2);
    check("full_nwr", wr_n - base, 4);
    check("full_err_hold", {31'b0, err}, 32'd1);
    // inter-byte timeout
    do_reset();
    pulse_start();
    send(8'hAB); send(8'hCD);
    idle(9);
    check("tmo_err_early", {31'b0, err}, 32'd0);
    idle(1);
    check("tmo_err", {31'b0, err}, 32'd1);
    check("tmo_load", {31'b0, loading}, 32'd0);
    check("tmo_nwr", wr_n - base, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
